xy_scan_ctrl: RTL

//  Raster-scan index controller for the x/y index registers. On start it walks
//  y = 0..Y_SIZE-1 (outer) and x = 0..X_SIZE-1 (inner). For each register it drives
//  the next index value plus single-cycle enable and clear strobes. It presents one

---
 rtl/xy_scan_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/xy_scan_ctrl.sv
// Raster-scan controller for the x/y index registers: walks y (outer) and x (inner),
// drives load/clear strobes for both registers and presents one valid pair per beat.
module xy_scan_ctrl #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [IDX_W-1:0] x_size_i,
  input  logic [IDX_W-1:0] y_size_i,
  input  logic             stall_i,
  output logic [IDX_W-1:0] x_ind_o,
  output logic             x_ind_en_o,
  output logic             x_ind_clr_o,
  output logic [IDX_W-1:0] y_ind_o,
  output logic             y_ind_en_o,
  output logic             y_ind_clr_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       state_dbg_o
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] SCAN  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [IDX_W-1:0] ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  // Handshake: in a cycle with valid_o=1 the index registers hold the pair being
  // presented. The beat completes when stall_i was low at the edge that opened the
  // cycle; that cycle then carries the en/clr strobes that load the next pair.
  // A stalled beat repeats with valid_o=1, the same pair and no strobes.

  logic [1:0]       state;
  logic [1:0]       state_n;
  logic [IDX_W-1:0] x_size;
  logic [IDX_W-1:0] y_size;
  logic [IDX_W-1:0] x_cnt;
  logic [IDX_W-1:0] y_cnt;
  logic [IDX_W-1:0] bx;
  logic [IDX_W-1:0] by;
  logic             adv_q;
  logic             bx_end;
  logic             by_end;

  assign state_dbg_o = state;
  assign bx_end      = (bx == x_size - ONE);
  assign by_end      = (by == y_size - ONE);

  // Next state and the beat (bx,by) that will be presented in the next cycle.
  always_comb begin
    state_n = state;
    bx      = x_cnt;
    by      = y_cnt;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_n = ((x_size_i == '0) || (y_size_i == '0)) ? DONE : CLEAR;
          bx      = '0;
          by      = '0;
        end
      end
      CLEAR: begin
        state_n = SCAN;
        bx      = '0;
        by      = '0;
      end
      SCAN: begin
        if (adv_q) begin
          if (last_o) begin
            state_n = DONE;
          end else if (x_cnt != x_size - ONE) begin
            bx = x_cnt + ONE;
          end else begin
            bx = '0;
            by = y_cnt + ONE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x_size      <= '0;
      y_size      <= '0;
      x_cnt       <= '0;
      y_cnt       <= '0;
      adv_q       <= 1'b0;
      x_ind_o     <= '0;
      x_ind_en_o  <= 1'b0;
      x_ind_clr_o <= 1'b0;
      y_ind_o     <= '0;
      y_ind_en_o  <= 1'b0;
      y_ind_clr_o <= 1'b0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_n;
      x_cnt       <= bx;
      y_cnt       <= by;
      adv_q       <= 1'b0;
      x_ind_o     <= '0;
      x_ind_en_o  <= 1'b0;
      x_ind_clr_o <= 1'b0;
      y_ind_o     <= '0;
      y_ind_en_o  <= 1'b0;
      y_ind_clr_o <= 1'b0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      done_o      <= 1'b0;
      busy_o      <= (state_n != IDLE);

      if ((state == IDLE) && start_i) begin
        x_size <= x_size_i;
        y_size <= y_size_i;
      end

      case (state_n)
        CLEAR: begin
          x_ind_clr_o <= 1'b1;
          y_ind_clr_o <= 1'b1;
        end
        SCAN: begin
          valid_o <= 1'b1;
          last_o  <= bx_end && by_end;
          if (!stall_i) begin
            adv_q <= 1'b1;
            if (!bx_end) begin
              x_ind_o    <= bx + ONE;
              x_ind_en_o <= 1'b1;
            end else begin
              x_ind_clr_o <= 1'b1;
              if (!by_end) begin
                y_ind_o    <= by + ONE;
                y_ind_en_o <= 1'b1;
              end else begin
                y_ind_clr_o <= 1'b1;
              end
            end
          end
        end
        DONE: done_o <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
